// File: rtl/idu_pipe_wide_pkg.sv
// Shared idu defines: lane/payload defaults, payload field map, occupancy width.
// Imported by idu_pipe_wide and lane_popcount.
package idu_pipe_wide_pkg;

  localparam int unsigned IDU_LANES     = 2;
  localparam int unsigned IDU_PAYLOAD_W = 128;
  localparam int unsigned IDU_OCC_W     = 2;

  // Decoded-bundle field offsets within one lane payload.
  localparam int unsigned IDU_INSTR_LSB = 0;
  localparam int unsigned IDU_INSTR_W   = 32;
  localparam int unsigned IDU_PC_LSB    = 32;
  localparam int unsigned IDU_PC_W      = 32;
  localparam int unsigned IDU_LREG_LSB  = 64;
  localparam int unsigned IDU_LREG_W    = 16;
  localparam int unsigned IDU_IMM_LSB   = 80;
  localparam int unsigned IDU_IMM_W     = 32;
  localparam int unsigned IDU_CTRL_LSB  = 112;
  localparam int unsigned IDU_CTRL_W    = 16;

  typedef enum logic [IDU_OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/idu_pipe_wide_lane_popcount.sv
// Counts set bits of a lane mask.
// Ports: mask (LANES) in, count (CNT_W) out.
module lane_popcount
  import idu_pipe_wide_pkg::*;
#(
  parameter int LANES = IDU_LANES,
  parameter int CNT_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] mask,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      count = count + CNT_W'(mask[i]);
    end
  end

endmodule

// File: rtl/idu_pipe_wide.sv
// Decode-to-issue group buffer: 2-entry head+skid, registered up_ready.
// Ports: clock/reset, flush_valid, up_* (valid/ready/mask/payload in),
// down_* (valid/mask/payload out, ready in), occupancy.
// Optional macro IDU_PIPE_PERF_EN adds perf_instr_cnt / perf_stall_cnt.
module idu_pipe_wide
  import idu_pipe_wide_pkg::*;
#(
  parameter int LANES     = IDU_LANES,
  parameter int PAYLOAD_W = IDU_PAYLOAD_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush_valid,
  input  logic                       up_valid,
  input  logic [LANES-1:0]           up_lane_mask,
  input  logic [LANES*PAYLOAD_W-1:0] up_payload,
  output logic                       up_ready,
  output logic                       down_valid,
  output logic [LANES-1:0]           down_lane_mask,
  output logic [LANES*PAYLOAD_W-1:0] down_payload,
  input  logic                       down_ready,
`ifdef IDU_PIPE_PERF_EN
  output logic [63:0]                perf_instr_cnt,
  output logic [31:0]                perf_stall_cnt,
`endif
  output logic [IDU_OCC_W-1:0]       occupancy
);

  occ_e                       state_q, state_d;
  logic [LANES-1:0]           head_mask, skid_mask;
  logic [LANES*PAYLOAD_W-1:0] head_data, skid_data;
  logic                       push, pop;
  logic                       head_ld, head_from_skid, skid_ld;

  assign occupancy  = state_q;
  assign up_ready   = (state_q != OCC_FULL);
  // Flush kills the head combinationally so nothing leaves that cycle.
  assign down_valid = (state_q != OCC_EMPTY) && !flush_valid;
  // An empty mask is a bubble, not a group.
  assign push = up_valid && (|up_lane_mask) && up_ready && !flush_valid;
  assign pop  = down_valid && down_ready;

  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush_valid) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            head_ld = 1'b1;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_ld = 1'b1;
          end else if (push) begin
            skid_ld = 1'b1;
            state_d = OCC_FULL;
          end else if (pop) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head_ld        = 1'b1;
            head_from_skid = 1'b1;
            state_d        = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= OCC_EMPTY;
      head_mask <= '0;
      head_data <= '0;
      skid_mask <= '0;
      skid_data <= '0;
    end else begin
      state_q <= state_d;
      if (head_ld) begin
        head_mask <= head_from_skid ? skid_mask : up_lane_mask;
        head_data <= head_from_skid ? skid_data : up_payload;
      end
      if (skid_ld) begin
        skid_mask <= up_lane_mask;
        skid_data <= up_payload;
      end
    end
  end

  always_comb begin
    down_lane_mask = down_valid ? head_mask : '0;
    down_payload   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (down_lane_mask[i]) begin
        down_payload[i*PAYLOAD_W +: PAYLOAD_W] =
          head_data[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

`ifdef IDU_PIPE_PERF_EN
  localparam int CNT_W = $clog2(LANES + 1);

  logic [CNT_W-1:0] pop_cnt;

  lane_popcount #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) u_popcount (
    .mask  (down_lane_mask),
    .count (pop_cnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_instr_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop) begin
        perf_instr_cnt <= perf_instr_cnt + 64'(pop_cnt);
      end
      if (down_valid && !down_ready && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Lane masks must be contiguous from lane 0 (i.e. of the form 2^k-1).
  always @(posedge clock) begin
    if (!reset && up_valid && (up_lane_mask != '0)) begin
      assert ((up_lane_mask & (up_lane_mask + LANES'(1))) == '0)
        else $error("idu_pipe_wide: non-contiguous lane mask %b",
                    up_lane_mask);
    end
  end
`endif

endmodule
